seq_multiplier: RTL and testbench

SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

---
 rtl/seq_multiplier.sv | 146 ++++++++++++++
 tb/tb_seq_multiplier.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_multiplier.sv
// seq_multiplier: radix-2 shift-add multiplier, one multiplier bit per clock.
// Supports unsigned and two's-complement operands, selected per request.
//
// Ports:
//   clk          - clock, all state updates on rising edge
//   rst_n        - asynchronous active-low reset
//   start        - request a multiply; accepted only while busy is low
//   signed_mode  - 1: operands are two's complement, 0: unsigned (captured with operands)
//   a            - multiplicand, WIDTH bits
//   b            - multiplier, WIDTH bits
//   busy         - high while a multiply is in progress
//   done         - one-cycle pulse when product holds a new result
//   product      - 2*WIDTH-bit result of the last completed multiply
module seq_multiplier #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic              w_accept;

    logic [PW-1:0]     r_mcand;
    logic [WIDTH-1:0]  r_mplier;
    logic [PW-1:0]     r_acc;
    logic [CW-1:0]     r_cnt;
    logic              r_signed;
    logic              r_busy;
    logic              r_done;
    logic [PW-1:0]     r_product;

    logic [PW-1:0]     w_a_ext;
    logic [PW-1:0]     w_addend;
    logic              w_last;
    logic [PW-1:0]     w_acc_next;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and start acceptance
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = CALC;
                end
            end
            CALC: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    w_accept     = 1'b1;
                    w_state_next = CALC;
                end else begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    // Multiplicand extended to product width; sign-extended only in signed mode
    assign w_a_ext = {{WIDTH{signed_mode & a[WIDTH-1]}}, a};

    // Shift-add step. In signed mode the multiplier MSB carries weight -2^(WIDTH-1),
    // so the final partial product is subtracted instead of added. Arithmetic is
    // modulo 2^PW, which makes the sign-extended multiplicand produce the exact result.
    assign w_addend   = r_mplier[0] ? r_mcand : '0;
    assign w_last     = (r_cnt == CW'(WIDTH - 1));
    assign w_acc_next = (w_last && r_signed) ? (r_acc - w_addend) : (r_acc + w_addend);

    // Operand capture and accumulation datapath
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_acc     <= '0;
            r_cnt     <= '0;
            r_signed  <= 1'b0;
            r_product <= '0;
        end else if (w_accept) begin
            r_mcand   <= w_a_ext;
            r_mplier  <= b;
            r_signed  <= signed_mode;
            r_acc     <= '0;
            r_cnt     <= '0;
        end else if (r_state == CALC) begin
            r_acc     <= w_acc_next;
            r_mcand   <= r_mcand << 1;
            r_mplier  <= r_mplier >> 1;
            r_cnt     <= r_cnt + CW'(1);
            // Product is only updated on the edge that enters DONE
            if (w_last) begin
                r_product <= w_acc_next;
            end
        end
    end

    // Status outputs registered from the next state so they align with r_state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_busy <= (w_state_next == CALC);
            r_done <= (w_state_next == DONE);
        end
    end

    assign busy    = r_busy;
    assign done    = r_done;
    assign product = r_product;

endmodule

// File: tb/tb_seq_multiplier.sv
// Testbench for seq_multiplier: five instances (WIDTH 2,4,5,8,16) sharing the
// operand buses, each with its own start. Expected products are pushed to a
// scoreboard queue when a request is issued and popped when done is seen.
module tb_seq_multiplier;

    localparam int NI = 5;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [NI-1:0]  st;
    logic           sm;
    logic [15:0]    a_bus;
    logic [15:0]    b_bus;
    logic [NI-1:0]  bz;
    logic [NI-1:0]  dn;
    logic [3:0]     p2;
    logic [7:0]     p4;
    logic [9:0]     p5;
    logic [15:0]    p8;
    logic [31:0]    p16;

    int             n_cmp = 0;
    int             n_bad = 0;
    logic [31:0]    sb[$];

    always #5 clk = ~clk;

    seq_multiplier #(.WIDTH(2)) u_w2 (
        .clk(clk), .rst_n(rst_n), .start(st[0]), .signed_mode(sm),
        .a(a_bus[1:0]), .b(b_bus[1:0]), .busy(bz[0]), .done(dn[0]), .product(p2));
    seq_multiplier #(.WIDTH(4)) u_w4 (
        .clk(clk), .rst_n(rst_n), .start(st[1]), .signed_mode(sm),
        .a(a_bus[3:0]), .b(b_bus[3:0]), .busy(bz[1]), .done(dn[1]), .product(p4));
    seq_multiplier #(.WIDTH(5)) u_w5 (
        .clk(clk), .rst_n(rst_n), .start(st[2]), .signed_mode(sm),
        .a(a_bus[4:0]), .b(b_bus[4:0]), .busy(bz[2]), .done(dn[2]), .product(p5));
    seq_multiplier #(.WIDTH(8)) u_w8 (
        .clk(clk), .rst_n(rst_n), .start(st[3]), .signed_mode(sm),
        .a(a_bus[7:0]), .b(b_bus[7:0]), .busy(bz[3]), .done(dn[3]), .product(p8));
    seq_multiplier #(.WIDTH(16)) u_w16 (
        .clk(clk), .rst_n(rst_n), .start(st[4]), .signed_mode(sm),
        .a(a_bus), .b(b_bus), .busy(bz[4]), .done(dn[4]), .product(p16));

    function automatic int wid(input int idx);
        case (idx)
            0: return 2;
            1: return 4;
            2: return 5;
            3: return 8;
            default: return 16;
        endcase
    endfunction

    function automatic logic [31:0] prod_of(input int idx);
        case (idx)
            0: return 32'(p2);
            1: return 32'(p4);
            2: return 32'(p5);
            3: return 32'(p8);
            default: return p16;
        endcase
    endfunction

    // Reference model: integer multiply of the interpreted operands, truncated to 2*w bits
    function automatic logic [31:0] ref_mul(input int idx, input logic s,
                                            input logic [15:0] x, input logic [15:0] y);
        int          w;
        longint      xv;
        longint      yv;
        longint      pv;
        logic [63:0] r;
        w  = wid(idx);
        xv = longint'({48'd0, x}) & ((longint'(1) << w) - 1);
        yv = longint'({48'd0, y}) & ((longint'(1) << w) - 1);
        if (s && x[w-1]) xv = xv - (longint'(1) << w);
        if (s && y[w-1]) yv = yv - (longint'(1) << w);
        pv = xv * yv;
        r  = 64'(pv) & ((64'd1 << (2 * w)) - 64'd1);
        return r[31:0];
    endfunction

    // Drive a request at a falling edge; it is sampled on the following rising edge
    task automatic issue(input int idx, input logic s, input logic [15:0] x,
                         input logic [15:0] y, input logic [31:0] exp);
        @(negedge clk);
        a_bus   = x;
        b_bus   = y;
        sm      = s;
        st[idx] = 1'b1;
        sb.push_back(exp);
    endtask

    // Wait for done on one instance; cyc counts falling edges since the request
    // (done after rising edge k is seen at cyc = k+1). Operands are scrambled after
    // the accepting edge to show they are not used later.
    task automatic wait_done(input int idx, output logic [31:0] prod,
                             output int cyc, output bit ok);
        ok   = 1'b0;
        cyc  = 0;
        prod = '0;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) begin
                st    = '0;
                a_bus = 16'($urandom);
                b_bus = 16'($urandom);
                sm    = 1'($urandom);
            end
            if (dn[idx]) begin
                prod = prod_of(idx);
                ok   = 1'b1;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        st    = '0;
        sm    = 1'b0;
        a_bus = '0;
        b_bus = '0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (bz !== '0) begin n_bad++; $display("FAIL reset_busy got %b want 0", bz); end
        n_cmp++;
        if (dn !== '0) begin n_bad++; $display("FAIL reset_done got %b want 0", dn); end
        for (int i = 0; i < NI; i++) begin
            n_cmp++;
            if (prod_of(i) !== 32'd0) begin
                n_bad++;
                $display("FAIL reset_product w=%0d got %h want 0", wid(i), prod_of(i));
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_unsigned_w2();
        logic [31:0] got, exp;
        int          cyc;
        bit          ok;
        for (int x = 0; x < 4; x++) begin
            for (int y = 0; y < 4; y++) begin
                issue(0, 1'b0, 16'(x), 16'(y), 32'(x * y));
                wait_done(0, got, cyc, ok);
                exp = sb.pop_front();
                n_cmp++;
                if (!ok || got !== exp) begin
                    n_bad++;
                    $display("FAIL w2_product %0d*%0d got %h (done=%0d) want %h", x, y, got, ok, exp);
                end
                n_cmp++;
                if (cyc != 3) begin
                    n_bad++;
                    $display("FAIL w2_latency %0d*%0d got %0d want 3", x, y, cyc);
                end
            end
        end
    endtask

    task automatic test_max_w4();
        logic [31:0] exp;
        issue(1, 1'b0, 16'd15, 16'd15, 32'h0E1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k == 0) st = '0;
            n_cmp++;
            if ({bz[1], dn[1]} !== 2'b10 || p4 !== 8'h00) begin
                n_bad++;
                $display("FAIL w4_calc edge%0d got busy=%b done=%b prod=%h want 1 0 00",
                         k, bz[1], dn[1], p4);
            end
        end
        @(negedge clk);
        exp = sb.pop_front();
        n_cmp++;
        if ({bz[1], dn[1]} !== 2'b01 || 32'(p4) !== exp) begin
            n_bad++;
            $display("FAIL w4_done got busy=%b done=%b prod=%h want 0 1 %h", bz[1], dn[1], p4, exp);
        end
        repeat (3) begin
            @(negedge clk);
            n_cmp++;
            if ({bz[1], dn[1]} !== 2'b00 || p4 !== 8'hE1) begin
                n_bad++;
                $display("FAIL w4_hold got busy=%b done=%b prod=%h want 0 0 e1", bz[1], dn[1], p4);
            end
        end
    endtask

    task automatic test_signed_w4();
        logic [15:0] xs[3] = '{16'hD, 16'h8, 16'h7};
        logic [15:0] ys[3] = '{16'h5, 16'h8, 16'h8};
        logic [31:0] es[3] = '{32'hF1, 32'h40, 32'hC8};
        logic [31:0] got, exp;
        int          cyc;
        bit          ok;
        for (int i = 0; i < 3; i++) begin
            issue(1, 1'b1, xs[i], ys[i], es[i]);
            wait_done(1, got, cyc, ok);
            exp = sb.pop_front();
            n_cmp++;
            if (!ok || got !== exp || cyc != 5) begin
                n_bad++;
                $display("FAIL w4_signed %h*%h got %h cyc=%0d want %h cyc=5", xs[i], ys[i], got, cyc, exp);
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [31:0] exp;
        int          cyc;
        int          extra;
        bit          seen;
        issue(1, 1'b0, 16'd3, 16'd2, 32'h06);
        @(negedge clk);                 // after edge 0
        st = '0;
        @(negedge clk);                 // after edge 1: request during CALC
        a_bus = 16'd5;
        b_bus = 16'd5;
        st[1] = 1'b1;
        @(negedge clk);                 // after edge 2
        st  = '0;
        cyc = 3;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            cyc++;
            if (dn[1]) seen = 1'b1;
        end
        exp = sb.pop_front();
        n_cmp++;
        if (!seen || 32'(p4) !== exp || cyc != 5) begin
            n_bad++;
            $display("FAIL ignore_start got %h cyc=%0d want %h cyc=5", p4, cyc, exp);
        end
        extra = 0;
        repeat (8) begin
            @(negedge clk);
            if (dn[1] || bz[1]) extra++;
        end
        n_cmp++;
        if (extra != 0 || p4 !== 8'h06) begin
            n_bad++;
            $display("FAIL ignore_start_idle got %0d active cycles prod=%h want 0 06", extra, p4);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        int          cyc;
        bit          seen;
        issue(1, 1'b0, 16'd3, 16'd4, 32'd12);
        @(negedge clk);                 // after edge 0; start stays high
        a_bus = 16'd7;
        b_bus = 16'd7;
        cyc  = 1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            cyc++;
            if (dn[1]) seen = 1'b1;
        end
        exp = sb.pop_front();
        n_cmp++;
        if (!seen || 32'(p4) !== exp || cyc != 5) begin
            n_bad++;
            $display("FAIL b2b_first got %h cyc=%0d want %h cyc=5", p4, cyc, exp);
        end
        sb.push_back(32'd49);           // accepted on the DONE edge
        @(negedge clk);
        st = '0;
        n_cmp++;
        if ({bz[1], dn[1]} !== 2'b10) begin
            n_bad++;
            $display("FAIL b2b_no_idle got busy=%b done=%b want 1 0", bz[1], dn[1]);
        end
        cyc  = 0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            cyc++;
            if (dn[1]) seen = 1'b1;
        end
        exp = sb.pop_front();
        n_cmp++;
        if (!seen || 32'(p4) !== exp || cyc != 4) begin
            n_bad++;
            $display("FAIL b2b_second got %h cyc=%0d want %h cyc=4", p4, cyc, exp);
        end
    endtask

    task automatic test_reset_midcalc();
        logic [31:0] got, exp;
        int          cyc;
        int          pulses;
        bit          ok;
        issue(3, 1'b0, 16'd3, 16'd5, 32'd15);
        wait_done(3, got, cyc, ok);
        exp = sb.pop_front();
        n_cmp++;
        if (!ok || got !== exp) begin
            n_bad++;
            $display("FAIL w8_pre got %h want %h", got, exp);
        end
        issue(3, 1'b0, 16'd200, 16'd100, 32'h4E20);
        @(negedge clk);                 // after edge 0
        st = '0;
        repeat (3) @(negedge clk);      // after edge 3
        #2 rst_n = 1'b0;
        #1;
        n_cmp++;
        if (bz[3] !== 1'b0 || dn[3] !== 1'b0 || p8 !== 16'h0) begin
            n_bad++;
            $display("FAIL async_reset got busy=%b done=%b prod=%h want 0 0 0000", bz[3], dn[3], p8);
        end
        sb.delete();
        pulses = 0;
        repeat (10) begin
            @(negedge clk);
            if (dn[3]) pulses++;
        end
        n_cmp++;
        if (pulses != 0 || p8 !== 16'h0) begin
            n_bad++;
            $display("FAIL reset_abandon got %0d done pulses prod=%h want 0 0000", pulses, p8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        // Released at the same falling edge the request is presented
        a_bus = 16'd200;
        b_bus = 16'd100;
        sm    = 1'b0;
        st[3] = 1'b1;
        sb.push_back(32'h4E20);
        wait_done(3, got, cyc, ok);
        exp = sb.pop_front();
        n_cmp++;
        if (!ok || got !== exp || cyc != 9) begin
            n_bad++;
            $display("FAIL w8_after_reset got %h cyc=%0d want %h cyc=9", got, cyc, exp);
        end
    endtask

    task automatic test_random();
        int          idxs[4] = '{0, 2, 3, 4};
        int          n_acc  = 0;
        int          n_done = 0;
        int          idx, w, cyc;
        logic        s;
        logic [15:0] x, y;
        logic [31:0] got, exp;
        bit          ok;
        for (int k = 0; k < 4; k++) begin
            idx = idxs[k];
            w   = wid(idx);
            for (int n = 0; n < 12; n++) begin
                s = 1'($urandom);
                x = 16'($urandom);
                y = 16'($urandom);
                case ($urandom_range(0, 3))
                    0: x = 16'hFFFF;
                    1: begin x = 16'(1) << (w - 1); y = x; end
                    default: ;
                endcase
                issue(idx, s, x, y, ref_mul(idx, s, x, y));
                n_acc++;
                wait_done(idx, got, cyc, ok);
                if (ok) n_done++;
                exp = sb.pop_front();
                n_cmp++;
                if (!ok || got !== exp || cyc != w + 1) begin
                    n_bad++;
                    $display("FAIL rand w=%0d s=%0d a=%h b=%h got %h cyc=%0d want %h cyc=%0d",
                             w, s, x, y, got, cyc, exp, w + 1);
                end
            end
        end
        n_cmp++;
        if (n_done != n_acc) begin
            n_bad++;
            $display("FAIL rand_done_count got %0d want %0d", n_done, n_acc);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired before completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_unsigned_w2();
        test_max_w4();
        test_signed_w4();
        test_ignore_start();
        test_back_to_back();
        test_reset_midcalc();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
